// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Frame format is fixed: 8 data bits, no parity, 1 stop bit, LSB first.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; 2-cycle latency, no backpressure.
// The reset value is a parameter so idle-high lines come out of reset without a false edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit confirmed at mid-bit, data sampled mid-bit, one-cycle valid/frame_err pulses.
// No flow control: the consumer must take o_rx_data in the cycle o_rx_valid is high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_frame_err,
  output logic       o_rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_BITS = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_BITS-1:0] HALF_LOAD = CNT_BITS'(HALF_BIT - 1);
  localparam logic [CNT_BITS-1:0] BIT_LOAD  = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [2:0]          LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                rx_s;
  rx_state_t           state_q;
  logic [CNT_BITS-1:0] clk_cnt_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          sr_q;
  logic [7:0]          data_q;
  logic                valid_q;
  logic                ferr_q;
  logic                busy_q;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt_q <= HALF_LOAD;
            state_q   <= START;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt_q != '0) begin
            clk_cnt_q <= clk_cnt_q - CNT_ONE;
          end else if (!rx_s) begin
            clk_cnt_q <= BIT_LOAD;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            // Start bit vanished before mid-bit: treat as line noise.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DATA: begin
          if (clk_cnt_q != '0) begin
            clk_cnt_q <= clk_cnt_q - CNT_ONE;
          end else begin
            sr_q      <= {rx_s, sr_q[7:1]};
            clk_cnt_q <= BIT_LOAD;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (clk_cnt_q != '0) begin
            clk_cnt_q <= clk_cnt_q - CNT_ONE;
          end else if (rx_s) begin
            // Leaving mid-stop-bit leaves half a bit to catch a back-to-back start.
            data_q  <= sr_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= BREAK;
          end
        end
        BREAK: begin
          // A line held low must return high before a new start can be seen.
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data      = data_q;
  assign o_rx_valid     = valid_q;
  assign o_rx_frame_err = ferr_q;
  assign o_rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: instance A at CLKS_PER_BIT=4, instance B at the default 2 fed by a behavioural transmitter.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] da, db;
  logic       va, vb, fa, fb, ba, bb;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  logic [7:0] qa_dat[$];
  int         qa_cyc[$];
  logic [7:0] qb_dat[$];
  int         ferr_a = 0, ferr_b = 0, ovl_a = 0, ovl_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .i_rx(rx_a),
    .o_rx_data(da), .o_rx_valid(va), .o_rx_frame_err(fa), .o_rx_busy(ba)
  );

  uart_rx dut_b (
    .clk(clk), .rst(rst), .i_rx(rx_b),
    .o_rx_data(db), .o_rx_valid(vb), .o_rx_frame_err(fb), .o_rx_busy(bb)
  );

  // Record pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (va === 1'b1) begin
      qa_dat.push_back(da);
      qa_cyc.push_back(cyc);
    end
    if (fa === 1'b1) ferr_a++;
    if (va === 1'b1 && fa === 1'b1) ovl_a++;
    if (vb === 1'b1) qb_dat.push_back(db);
    if (fb === 1'b1) ferr_b++;
    if (vb === 1'b1 && fb === 1'b1) ovl_b++;
  end

  task automatic clear_mon();
    qa_dat.delete();
    qa_cyc.delete();
    qb_dat.delete();
    ferr_a = 0; ferr_b = 0; ovl_a = 0; ovl_b = 0;
  endtask

  task automatic drive_bit(input bit sel, input logic b, input int cpb);
    if (sel) rx_b = b;
    else     rx_a = b;
    repeat (cpb) @(negedge clk);
  endtask

  // Called at a falling edge; t0 is the index of the first rising edge that sees the start bit.
  task automatic send(input bit sel, input int cpb, input logic [7:0] d, input logic stop, output int t0);
    t0 = cyc + 1;
    drive_bit(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], cpb);
    drive_bit(sel, stop, cpb);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (da !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", da); end
    tests_run++; if (va !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", va); end
    tests_run++; if (fa !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", fa); end
    tests_run++; if (ba !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", ba); end
    tests_run++; if (bb !== 1'b0 || db !== 8'h00) begin fails++; $display("FAIL reset_b got busy=%b data=%h exp 0/00", bb, db); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (ba !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy got=%b exp=0", ba); end
  endtask

  task automatic test_basic();
    int t0;
    clear_mon();
    send(1'b0, 4, 8'hA5, 1'b1, t0);
    repeat (4) @(negedge clk);
    tests_run++; if (qa_dat.size() !== 1) begin fails++; $display("FAIL basic_pulses got=%0d exp=1", qa_dat.size()); end
    if (qa_dat.size() >= 1) begin
      tests_run++; if (qa_dat[0] !== 8'hA5) begin fails++; $display("FAIL basic_data got=%h exp=a5", qa_dat[0]); end
      tests_run++; if (qa_cyc[0] - t0 !== 40) begin fails++; $display("FAIL basic_latency got=%0d exp=40", qa_cyc[0] - t0); end
    end
    tests_run++; if (da !== 8'hA5) begin fails++; $display("FAIL basic_hold got=%h exp=a5", da); end
    tests_run++; if (ferr_a !== 0) begin fails++; $display("FAIL basic_ferr got=%0d exp=0", ferr_a); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (ba !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise got=%b exp=1", ba); end
    repeat (10) @(negedge clk);
    tests_run++; if (ba !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall got=%b exp=0", ba); end
    tests_run++; if (qa_dat.size() !== 0 || ferr_a !== 0) begin fails++; $display("FAIL glitch_pulses got valid=%0d ferr=%0d exp 0/0", qa_dat.size(), ferr_a); end
    tests_run++; if (da !== 8'hA5) begin fails++; $display("FAIL glitch_data got=%h exp=a5", da); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_mon();
    send(1'b0, 4, 8'h3C, 1'b0, t0);
    repeat (20) @(negedge clk);
    tests_run++; if (ferr_a !== 1) begin fails++; $display("FAIL ferr_count got=%0d exp=1", ferr_a); end
    tests_run++; if (ba !== 1'b1) begin fails++; $display("FAIL ferr_break_busy got=%b exp=1", ba); end
    tests_run++; if (da !== 8'hA5) begin fails++; $display("FAIL ferr_data got=%h exp=a5", da); end
    rx_a = 1'b1;
    repeat (12) @(negedge clk);
    tests_run++; if (ba !== 1'b0) begin fails++; $display("FAIL ferr_release_busy got=%b exp=0", ba); end
    tests_run++; if (qa_dat.size() !== 0 || ferr_a !== 1) begin fails++; $display("FAIL ferr_spurious got valid=%0d ferr=%0d exp 0/1", qa_dat.size(), ferr_a); end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    clear_mon();
    send(1'b0, 4, 8'h00, 1'b1, t0);
    send(1'b0, 4, 8'hFF, 1'b1, t1);
    repeat (6) @(negedge clk);
    tests_run++; if (qa_dat.size() !== 2) begin fails++; $display("FAIL b2b_pulses got=%0d exp=2", qa_dat.size()); end
    if (qa_dat.size() >= 2) begin
      tests_run++; if (qa_dat[0] !== 8'h00) begin fails++; $display("FAIL b2b_data0 got=%h exp=00", qa_dat[0]); end
      tests_run++; if (qa_dat[1] !== 8'hFF) begin fails++; $display("FAIL b2b_data1 got=%h exp=ff", qa_dat[1]); end
      tests_run++; if (qa_cyc[0] - t0 !== 40) begin fails++; $display("FAIL b2b_latency got=%0d exp=40", qa_cyc[0] - t0); end
      tests_run++; if (qa_cyc[1] - qa_cyc[0] !== 40) begin fails++; $display("FAIL b2b_spacing got=%0d exp=40", qa_cyc[1] - qa_cyc[0]); end
    end
    tests_run++; if (ferr_a !== 0 || ovl_a !== 0) begin fails++; $display("FAIL b2b_ferr got ferr=%0d overlap=%0d exp 0/0", ferr_a, ovl_a); end
  endtask

  task automatic test_reset_midframe();
    int t0;
    logic [7:0] d;
    d = 8'h55;
    clear_mon();
    drive_bit(1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i], 4);
    drive_bit(1'b0, d[3], 2);
    // The transmitter shares the reset, so the line returns to idle with it.
    rst = 1'b1; rx_a = 1'b1;
    @(negedge clk);
    tests_run++; if (da !== 8'h00 || va !== 1'b0 || fa !== 1'b0 || ba !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs got data=%h v=%b fe=%b busy=%b exp 00/0/0/0", da, va, fa, ba);
    end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    tests_run++; if (qa_dat.size() !== 0 || ferr_a !== 0) begin fails++; $display("FAIL midrst_pulses got valid=%0d ferr=%0d exp 0/0", qa_dat.size(), ferr_a); end
    send(1'b0, 4, 8'h81, 1'b1, t0);
    repeat (4) @(negedge clk);
    tests_run++; if (qa_dat.size() !== 1) begin fails++; $display("FAIL midrst_next_pulses got=%0d exp=1", qa_dat.size()); end
    tests_run++; if (da !== 8'h81) begin fails++; $display("FAIL midrst_next_data got=%h exp=81", da); end
  endtask

  task automatic test_loopback();
    int t;
    clear_mon();
    for (int i = 0; i < 256; i++) send(1'b1, 2, 8'(i), 1'b1, t);
    repeat (6) @(negedge clk);
    tests_run++; if (qb_dat.size() !== 256) begin fails++; $display("FAIL loop_count got=%0d exp=256", qb_dat.size()); end
    for (int i = 0; i < 256 && i < qb_dat.size(); i++) begin
      tests_run++; if (qb_dat[i] !== 8'(i)) begin fails++; $display("FAIL loop_data[%0d] got=%h exp=%h", i, qb_dat[i], 8'(i)); end
    end
    tests_run++; if (ferr_b !== 0 || ovl_b !== 0) begin fails++; $display("FAIL loop_ferr got ferr=%0d overlap=%0d exp 0/0", ferr_b, ovl_b); end
    tests_run++; if (bb !== 1'b0) begin fails++; $display("FAIL loop_busy got=%b exp=0", bb); end
  endtask

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached tests=%0d failed=%0d", tests_run, fails);
    $fatal(1, "watchdog");
  end

endmodule
